// File: rtl/cnn_pkg.sv
// cnn_pkg: shared definitions for the CNN streaming stages.
//   T_DEF/L_DEF/P_DEF : default sample width, frame length and pool window.
//   smax()            : signed maximum on a wide signed type; callers sign-extend
//                       their T-bit operands into it and truncate the result back.
//   cnt_w()           : counter width for a modulo-n counter (minimum 1 bit).
package cnn_pkg;

   localparam int unsigned T_DEF  = 16;
   localparam int unsigned L_DEF  = 23;
   localparam int unsigned P_DEF  = 2;

   // Widest sample width smax() can handle without losing bits.
   localparam int unsigned SMAX_W = 64;

   typedef logic signed [SMAX_W-1:0] wide_t;

   function automatic wide_t smax(input wide_t a, input wide_t b);
      return (a > b) ? a : b;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stream_out_reg.sv
// stream_out_reg: single-entry registered valid/ready output stage.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   load_i         : write a new entry (only asserted when free_o is high)
//   data_i, last_i : payload of the new entry
//   ready_i        : downstream accepts the current entry
//   valid_o        : entry present
//   data_o, last_o : registered payload, stable while valid_o && !ready_i
//   free_o         : a new entry may be loaded this cycle (!valid_o || ready_i)
// A load on the same edge as a consume replaces the old entry; a consume with no
// load empties the stage and clears last_o (data_o keeps its last value).
module stream_out_reg #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         last_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         last_o,
   output logic         free_o
);

   logic         valid_q, valid_d;
   logic         last_q,  last_d;
   logic [W-1:0] data_q,  data_d;

   always_comb begin
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         last_d  = last_i;
         data_d  = data_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign last_o  = last_q;
   assign data_o  = data_q;
   assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/maxpool_1d_stream.sv
// maxpool_1d_stream: streaming 1-D max-pool, non-overlapping windows of P samples
// over frames of L signed T-bit samples. Trailing samples that do not fill a
// window are accepted and dropped.
//   clk, reset               : clock, asynchronous active-high reset
//   x_data, x_valid, x_ready : input sample stream (x_ready is combinational)
//   y_data, y_valid, y_ready : pooled maximum stream (registered)
//   y_last                   : marks the final pooled output of a frame
module maxpool_1d_stream
   import cnn_pkg::*;
#(
   parameter int unsigned L = L_DEF,
   parameter int unsigned P = P_DEF,
   parameter int unsigned T = T_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic signed [T-1:0] x_data,
   input  logic                x_valid,
   output logic                x_ready,
   output logic signed [T-1:0] y_data,
   output logic                y_valid,
   input  logic                y_ready,
   output logic                y_last
);

   if (P < 1 || L < P || T < 1 || T > SMAX_W) begin : g_bad_params
      $error("maxpool_1d_stream: illegal parameters (need P >= 1, L >= P, 1 <= T <= 64)");
   end

   localparam int unsigned WIN_W = cnt_w(P);
   localparam int unsigned POS_W = cnt_w(L);
   localparam int unsigned NW    = L / P;

   localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(P - 1);
   localparam logic [POS_W-1:0] POS_LAST  = POS_W'(L - 1);
   localparam logic [POS_W-1:0] FULL_LAST = POS_W'(NW * P - 1);

   logic [WIN_W-1:0]    win_q, win_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic signed [T-1:0] max_q, max_d;
   logic signed [T-1:0] win_max;
   logic                accept;
   logic                emit;
   logic                emit_last;

   always_comb begin
      // Running max including the current sample; a window's first sample
      // restarts it, which also makes P==1 a plain pass-through.
      win_max   = (win_q == '0) ? x_data
                                : T'(smax(SMAX_W'(max_q), SMAX_W'(x_data)));
      accept    = x_valid && x_ready;
      emit      = accept && (win_q == WIN_LAST) && (pos_q <= FULL_LAST);
      emit_last = (pos_q == FULL_LAST);

      win_d = win_q;
      pos_d = pos_q;
      max_d = max_q;
      if (accept) begin
         max_d = win_max;
         if (pos_q == POS_LAST) begin
            win_d = '0;
            pos_d = '0;
         end else begin
            pos_d = pos_q + 1'b1;
            win_d = (win_q == WIN_LAST) ? '0 : win_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_q <= '0;
         pos_q <= '0;
         max_q <= '0;
      end else begin
         win_q <= win_d;
         pos_q <= pos_d;
         max_q <= max_d;
      end
   end

   stream_out_reg #(
      .W (T)
   ) u_out (
      .clk_i   (clk),
      .rst_i   (reset),
      .load_i  (emit),
      .data_i  (win_max),
      .last_i  (emit_last),
      .ready_i (y_ready),
      .valid_o (y_valid),
      .data_o  (y_data),
      .last_o  (y_last),
      .free_o  (x_ready)
   );

endmodule

// File: tb/tb_maxpool_1d_stream.sv
module tb_maxpool_1d_stream;

   localparam int T = 16;

   logic                clk = 1'b0;
   logic                reset;
   logic signed [T-1:0] x_data;
   logic                x_valid;
   logic                x_ready;
   logic signed [T-1:0] y_data;
   logic                y_valid;
   logic                y_ready;
   logic                y_last;

   maxpool_1d_stream #(
      .L (23),
      .P (2),
      .T (T)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .x_data  (x_data),
      .x_valid (x_valid),
      .x_ready (x_ready),
      .y_data  (y_data),
      .y_valid (y_valid),
      .y_ready (y_ready),
      .y_last  (y_last)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int xr_low   = 0;
   int out_q[$];
   int last_q[$];
   int out_cyc[$];
   int acc_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Observe handshakes half a cycle before the edge that completes them.
   always @(negedge clk) begin
      if (!reset) begin
         if (y_valid && y_ready) begin
            out_q.push_back(int'(y_data));
            last_q.push_back(int'(y_last));
            out_cyc.push_back(cyc);
         end
         if (x_valid && x_ready) acc_cyc.push_back(cyc);
         if (!x_ready) xr_low++;
      end
   end

   task automatic check_val(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      out_q.delete();
      last_q.delete();
      out_cyc.delete();
      acc_cyc.delete();
      xr_low = 0;
   endtask

   task automatic send(input int v);
      int w;
      w       = 0;
      x_data  = T'(v);
      x_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (x_ready) break;
         w++;
         if (w > 100) begin
            check_val("send_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      x_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      clear_mon();
   endtask

   task automatic compare_out(input string tag, input int exp_y[$], input int exp_l[$]);
      logic signed [31:0] g;
      check_val({tag, "_count"}, out_q.size(), exp_y.size());
      foreach (exp_y[k]) begin
         g = (k < out_q.size()) ? out_q[k] : 'x;
         check_val($sformatf("%s_y%0d", tag, k), g, exp_y[k]);
         g = (k < last_q.size()) ? last_q[k] : 'x;
         check_val($sformatf("%s_last%0d", tag, k), g, exp_l[k]);
      end
   endtask

   int exp_y[$];
   int exp_l[$];
   int v6[23] = '{3, -8, -100, -200, 40, 41, 0, -1, 12, 12, -7, 300,
                  50, -50, 9, 10, -32768, -32767, 32767, 0, 6, 5, 4999};
   int e6[11] = '{3, -100, 41, 0, 12, 300, 50, 10, -32767, 32767, 6};

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      x_valid = 1'b0;
      x_data  = '0;
      y_ready = 1'b1;

      // Reset state and asynchronous reset mid-cycle.
      #2;
      check_val("rst_y_valid", y_valid, 0);
      check_val("rst_y_data", y_data, 0);
      check_val("rst_y_last", y_last, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      #1 check_val("rst_x_ready", x_ready, 1);
      clear_mon();
      y_ready = 1'b0;
      send(-7);
      send(9);
      check_val("pre_arst_valid", y_valid, 1);
      check_val("pre_arst_data", y_data, 9);
      #2 reset = 1'b1;
      #1;
      check_val("arst_y_valid", y_valid, 0);
      check_val("arst_y_data", y_data, 0);
      check_val("arst_y_last", y_last, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      y_ready = 1'b1;
      #1 check_val("arst_x_ready", x_ready, 1);
      idle(1);
      clear_mon();

      // Continuous frame 0..22.
      for (int i = 0; i < 23; i++) send(i);
      idle(4);
      exp_y.delete(); exp_l.delete();
      for (int k = 0; k < 11; k++) begin
         exp_y.push_back(2 * k + 1);
         exp_l.push_back(k == 10 ? 1 : 0);
      end
      compare_out("cont", exp_y, exp_l);
      check_val("cont_accepted", acc_cyc.size(), 23);
      check_val("cont_xready_low", xr_low, 0);
      for (int k = 0; k < 11; k++) begin
         if (k < out_cyc.size() && 2 * k + 1 < acc_cyc.size())
            check_val($sformatf("cont_latency%0d", k), out_cyc[k] - acc_cyc[2 * k + 1], 1);
      end

      // Signed compare.
      do_reset();
      send(-5); send(-3); send(-32768); send(7);
      send(100); send(-1); send(4); send(4);
      idle(4);
      exp_y = '{-3, 7, 100, 4};
      exp_l = '{0, 0, 0, 0};
      compare_out("signed", exp_y, exp_l);

      // Backpressure after the first output.
      do_reset();
      fork
         begin
            for (int i = 0; i < 23; i++) send(i);
         end
         begin
            int w;
            w = 0;
            do begin
               @(posedge clk);
               #2;
               w++;
            end while (!y_valid && w < 50);
            check_val("bp_first_valid", y_valid, 1);
            y_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check_val("bp_hold_data", y_data, 1);
               check_val("bp_hold_valid", y_valid, 1);
               check_val("bp_x_ready", x_ready, 0);
            end
            @(posedge clk);
            #2 y_ready = 1'b1;
         end
      join
      idle(4);
      exp_y.delete(); exp_l.delete();
      for (int k = 0; k < 11; k++) begin
         exp_y.push_back(2 * k + 1);
         exp_l.push_back(k == 10 ? 1 : 0);
      end
      compare_out("bp", exp_y, exp_l);
      check_val("bp_accepted", acc_cyc.size(), 23);

      // Back-to-back frames; samples 22 and 45 are tails and must never appear.
      do_reset();
      for (int i = 0; i < 46; i++) begin
         if (i < 22)       send(i);
         else if (i == 22) send(1000);
         else if (i == 45) send(2000);
         else              send(200 - (i - 23));
      end
      idle(4);
      exp_y.delete(); exp_l.delete();
      for (int k = 0; k < 11; k++) begin
         exp_y.push_back(2 * k + 1);
         exp_l.push_back(k == 10 ? 1 : 0);
      end
      for (int k = 0; k < 11; k++) begin
         exp_y.push_back(200 - 2 * k);
         exp_l.push_back(k == 10 ? 1 : 0);
      end
      compare_out("b2b", exp_y, exp_l);

      // Reset after five accepted samples, then a fresh frame.
      do_reset();
      for (int i = 0; i < 5; i++) send(5000);
      #2 reset = 1'b1;
      #1 check_val("mid_rst_valid", y_valid, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      clear_mon();
      for (int i = 0; i < 23; i++) send(v6[i]);
      idle(4);
      exp_y.delete(); exp_l.delete();
      for (int k = 0; k < 11; k++) begin
         exp_y.push_back(e6[k]);
         exp_l.push_back(k == 10 ? 1 : 0);
      end
      compare_out("midrst", exp_y, exp_l);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
